// File: rtl/hd63701_intc_pkg.sv
// Shared constants for the HD63701 interrupt path: vector low bytes, IRQ2V
// nibble codes and the debug pending-mask layout. The sequencer imports the
// same package so both blocks agree on every vector value.
package hd63701_intc_pkg;

   // Low byte of each interrupt vector (high byte is always FF)
   localparam logic [7:0] VEC_NMI  = 8'hFC;
   localparam logic [7:0] VEC_IRQ1 = 8'hF8;
   localparam logic [7:0] VEC_ICF  = 8'hF6;
   localparam logic [7:0] VEC_OCF  = 8'hF4;
   localparam logic [7:0] VEC_TOF  = 8'hF2;
   localparam logic [7:0] VEC_SCI  = 8'hF0;

   // IRQ2V is the low nibble of the selected timer vector
   localparam logic [3:0] IRQ2V_ICF  = VEC_ICF[3:0];
   localparam logic [3:0] IRQ2V_OCF  = VEC_OCF[3:0];
   localparam logic [3:0] IRQ2V_TOF  = VEC_TOF[3:0];
   localparam logic [3:0] IRQ2V_NONE = 4'h0;

   // Bit positions inside PEND
   localparam int unsigned PEND_NMI = 6;
   localparam int unsigned PEND_IRQ = 5;
   localparam int unsigned PEND_ICF = 4;
   localparam int unsigned PEND_OCF = 3;
   localparam int unsigned PEND_TOF = 2;
   localparam int unsigned PEND_SCI = 1;

   // Enabled timer requests (flag & enable)
   typedef struct packed {
      logic icf;
      logic ocf;
      logic tof;
   } timer_req_t;

   // Fixed priority ICF > OCF > TOF
   function automatic logic [3:0] timer_vec(timer_req_t req);
      logic [3:0] v;
      if (req.icf) begin
         v = IRQ2V_ICF;
      end else if (req.ocf) begin
         v = IRQ2V_OCF;
      end else if (req.tof) begin
         v = IRQ2V_TOF;
      end else begin
         v = IRQ2V_NONE;
      end
      return v;
   endfunction

   // Assemble the debug pending mask; bits 7 and 0 are always zero
   function automatic logic [7:0] pend_mask(logic nmi, logic irq, timer_req_t req, logic sci);
      logic [7:0] m;
      m           = 8'h00;
      m[PEND_NMI] = nmi;
      m[PEND_IRQ] = irq;
      m[PEND_ICF] = req.icf;
      m[PEND_OCF] = req.ocf;
      m[PEND_TOF] = req.tof;
      m[PEND_SCI] = sci;
      return m;
   endfunction

endpackage

// File: rtl/hd63701_pinsync.sv
// Three-stage synchroniser for an asynchronous active-low pin. All stages
// reset to 1 so a reset pin reads as inactive; s3 is exposed for edge detect.
module hd63701_pinsync (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic s2,
   output logic s3
);

   logic s1;

   // Shift the pin through three flops, parking at the inactive level on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= pin;
         s2 <= s1;
         s3 <= s2;
      end
   end

endmodule

// File: rtl/hd63701_intc.sv
// Interrupt request conditioner for the HD63701 sequencer. Synchronises the
// NMI and IRQ1 pins, edge-latches NMI, merges enabled timer flags into
// IRQ2/IRQ2V and forwards the SCI request. Every output is a flop.
module hd63701_intc
   import hd63701_intc_pkg::*;
#(
   parameter int unsigned NMI_EDGE = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       NMI_N,
   input  logic       IRQ1_N,
   input  logic       ICF,
   input  logic       OCF,
   input  logic       TOF,
   input  logic       EICI,
   input  logic       EOCI,
   input  logic       ETOI,
   input  logic       SCIRQ,
   input  logic       VACK,
   input  logic [7:0] VNUM,
   output logic       NMI,
   output logic       IRQ,
   output logic       IRQ2,
   output logic [3:0] IRQ2V,
   output logic       IRQ0,
   output logic [7:0] PEND
);

   logic       nmi_s2;
   logic       nmi_s3;
   logic       irq1_s2;
   logic       irq1_s3;
   logic       unused_irq1_s3;

   logic       nmi_fall;
   logic       nmi_ack;
   logic       nmi_lat;
   logic       nmi_lat_d;
   logic       irq_d;
   timer_req_t tmr;
   logic       irq2_d;
   logic [3:0] irq2v_d;
   logic [7:0] pend_d;

   hd63701_pinsync u_nmi_sync (
      .clk (CLK),
      .rst (RST),
      .pin (NMI_N),
      .s2  (nmi_s2),
      .s3  (nmi_s3)
   );

   hd63701_pinsync u_irq1_sync (
      .clk (CLK),
      .rst (RST),
      .pin (IRQ1_N),
      .s2  (irq1_s2),
      .s3  (irq1_s3)
   );

   // IRQ1 is level-only, so its third stage has no consumer
   assign unused_irq1_s3 = irq1_s3;

   // s3 still high while s2 already low marks exactly one cycle per fall
   assign nmi_fall = nmi_s3 & ~nmi_s2;
   assign nmi_ack  = VACK & (VNUM == VEC_NMI);

   // NMI next state: latch with set beating clear, or the plain synchronised level
   always_comb begin
      nmi_lat_d = nmi_lat;
      if (NMI_EDGE != 0) begin
         if (nmi_ack) begin
            nmi_lat_d = 1'b0;
         end
         if (nmi_fall) begin
            nmi_lat_d = 1'b1;
         end
      end else begin
         nmi_lat_d = ~nmi_s2;
      end
   end

   // IRQ1 level, timer merge with priority vector, and the debug mask
   always_comb begin
      irq_d    = ~irq1_s2;
      tmr.icf  = ICF & EICI;
      tmr.ocf  = OCF & EOCI;
      tmr.tof  = TOF & ETOI;
      irq2_d   = tmr.icf | tmr.ocf | tmr.tof;
      irq2v_d  = timer_vec(tmr);
      pend_d   = pend_mask(nmi_lat_d, irq_d, tmr, SCIRQ);
   end

   // Output registers; IRQ2 and IRQ2V share an edge so they never disagree
   always_ff @(posedge CLK) begin
      if (RST) begin
         nmi_lat <= 1'b0;
         IRQ     <= 1'b0;
         IRQ2    <= 1'b0;
         IRQ2V   <= IRQ2V_NONE;
         IRQ0    <= 1'b0;
         PEND    <= 8'h00;
      end else begin
         nmi_lat <= nmi_lat_d;
         IRQ     <= irq_d;
         IRQ2    <= irq2_d;
         IRQ2V   <= irq2v_d;
         IRQ0    <= SCIRQ;
         PEND    <= pend_d;
      end
   end

   assign NMI = nmi_lat;

endmodule

// File: tb/tb_hd63701_intc.sv
// Directed bench for hd63701_intc: a cycle-history model predicts every
// output after each clock edge and a compare process checks them each cycle;
// literal expectations at key points pin both the DUT and the model.
module tb_hd63701_intc;

   logic       CLK = 1'b0;
   logic       RST;
   logic       NMI_N;
   logic       IRQ1_N;
   logic       ICF, OCF, TOF;
   logic       EICI, EOCI, ETOI;
   logic       SCIRQ;
   logic       VACK;
   logic [7:0] VNUM;
   logic       NMI, IRQ, IRQ2, IRQ0;
   logic [3:0] IRQ2V;
   logic [7:0] PEND;

   int total = 0;
   int bad   = 0;

   hd63701_intc dut (
      .CLK    (CLK),
      .RST    (RST),
      .NMI_N  (NMI_N),
      .IRQ1_N (IRQ1_N),
      .ICF    (ICF),
      .OCF    (OCF),
      .TOF    (TOF),
      .EICI   (EICI),
      .EOCI   (EOCI),
      .ETOI   (ETOI),
      .SCIRQ  (SCIRQ),
      .VACK   (VACK),
      .VNUM   (VNUM),
      .NMI    (NMI),
      .IRQ    (IRQ),
      .IRQ2   (IRQ2),
      .IRQ2V  (IRQ2V),
      .IRQ0   (IRQ0),
      .PEND   (PEND)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Per-edge input history; a pin seen "d edges late" reads idle (1) if any
   // reset fell inside that window or before time began.
   bit         rst_h [0:1023];
   bit         nmi_h [0:1023];
   bit         irq_h [0:1023];
   int         cyc      = 0;
   bit         model_ok = 1'b0;
   logic       exp_nmi  = 1'b0;
   logic       exp_irq, exp_irq2, exp_irq0;
   logic [3:0] exp_irq2v;
   logic [7:0] exp_pend;

   function automatic bit delayed(input bit is_irq, input int n, input int d);
      if (n - d < 0) return 1'b1;
      for (int k = n - d; k < n; k++) if (rst_h[k]) return 1'b1;
      return is_irq ? irq_h[n - d] : nmi_h[n - d];
   endfunction

   initial begin
      forever begin
         @(posedge CLK);
         if (cyc < 1024) begin
            rst_h[cyc] = RST;
            nmi_h[cyc] = NMI_N;
            irq_h[cyc] = IRQ1_N;
            if (RST) begin
               exp_nmi   = 1'b0;
               exp_irq   = 1'b0;
               exp_irq2  = 1'b0;
               exp_irq2v = 4'd0;
               exp_irq0  = 1'b0;
               exp_pend  = 8'd0;
            end else begin
               bit fell, ei, eo, et;
               fell = delayed(1'b0, cyc, 3) && !delayed(1'b0, cyc, 2);
               if (fell) exp_nmi = 1'b1;
               else if (VACK && VNUM == 8'hFC) exp_nmi = 1'b0;
               exp_irq  = !delayed(1'b1, cyc, 2);
               ei = ICF && EICI;
               eo = OCF && EOCI;
               et = TOF && ETOI;
               exp_irq2  = ei || eo || et;
               exp_irq2v = ei ? 4'd6 : eo ? 4'd4 : et ? 4'd2 : 4'd0;
               exp_irq0  = SCIRQ;
               exp_pend  = 8'd0;
               if (exp_nmi) exp_pend = exp_pend + 8'd64;
               if (exp_irq) exp_pend = exp_pend + 8'd32;
               if (ei)      exp_pend = exp_pend + 8'd16;
               if (eo)      exp_pend = exp_pend + 8'd8;
               if (et)      exp_pend = exp_pend + 8'd4;
               if (SCIRQ)   exp_pend = exp_pend + 8'd2;
            end
            cyc++;
            model_ok = 1'b1;
         end
      end
   end

   // Per-cycle comparison on the falling edge
   initial begin
      forever begin
         @(negedge CLK);
         if (model_ok) begin
            check("cyc_NMI",   {7'd0, NMI},  {7'd0, exp_nmi});
            check("cyc_IRQ",   {7'd0, IRQ},  {7'd0, exp_irq});
            check("cyc_IRQ2",  {7'd0, IRQ2}, {7'd0, exp_irq2});
            check("cyc_IRQ2V", {4'd0, IRQ2V}, {4'd0, exp_irq2v});
            check("cyc_IRQ0",  {7'd0, IRQ0}, {7'd0, exp_irq0});
            check("cyc_PEND",  PEND, exp_pend);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int first;
      int highs;

      RST = 1'b1; NMI_N = 1'b0; IRQ1_N = 1'b1;
      ICF = 1'b1; OCF = 1'b1; TOF = 1'b1;
      EICI = 1'b1; EOCI = 1'b1; ETOI = 1'b1;
      SCIRQ = 1'b1; VACK = 1'b0; VNUM = 8'h00;

      // Reset held 3 cycles with NMI low and every flag/enable set
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_NMI",  {7'd0, NMI},  8'd0);
         check("rst_IRQ2", {7'd0, IRQ2}, 8'd0);
         check("rst_IRQ0", {7'd0, IRQ0}, 8'd0);
         check("rst_PEND", PEND, 8'd0);
      end
      RST = 1'b0;
      ICF = 1'b0; OCF = 1'b0; TOF = 1'b0;
      EICI = 1'b0; EOCI = 1'b0; ETOI = 1'b0; SCIRQ = 1'b0;

      // The reset-to-1 s3 makes the already-low pin count as one fall
      tick();
      tick();
      check("rel1_NMI", {7'd0, NMI}, 8'd0);
      tick();
      check("rel2_NMI", {7'd0, NMI}, 8'd1);
      check("rel2_PEND", PEND, 8'h40);
      check("model_rel2_NMI", {7'd0, exp_nmi}, 8'd1);
      VACK = 1'b1; VNUM = 8'hFC;
      tick();
      VACK = 1'b0;
      check("ack_NMI", {7'd0, NMI}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("held_NMI", {7'd0, NMI}, 8'd0);
      end

      // Single-cycle pulse after re-arming
      NMI_N = 1'b1;
      tick(); tick(); tick();
      NMI_N = 1'b0;
      tick();
      NMI_N = 1'b1;
      tick();
      check("pulse1_NMI", {7'd0, NMI}, 8'd0);
      tick();
      check("pulse2_NMI", {7'd0, NMI}, 8'd1);
      VACK = 1'b1; VNUM = 8'hF8;
      tick();
      VACK = 1'b0;
      check("ackF8_NMI", {7'd0, NMI}, 8'd1);
      tick();
      check("keep_NMI", {7'd0, NMI}, 8'd1);

      // Fall arriving on the same edge as an FC ack: set wins
      NMI_N = 1'b0;
      tick();
      NMI_N = 1'b1;
      tick();
      VACK = 1'b1; VNUM = 8'hFC;
      tick();
      check("coinc_NMI", {7'd0, NMI}, 8'd1);
      check("model_coinc_NMI", {7'd0, exp_nmi}, 8'd1);
      tick();
      VACK = 1'b0;
      check("clr_NMI", {7'd0, NMI}, 8'd0);
      tick();

      // IRQ1 held low for 5 sampled edges
      IRQ1_N = 1'b0;
      first = -1;
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 4) IRQ1_N = 1'b1;
         if (IRQ === 1'b1) begin
            highs++;
            if (first < 0) first = i;
         end
      end
      check("irq1_count", highs[7:0], 8'd5);
      check("irq1_delay", first[7:0], 8'd2);

      // Timer priority
      OCF = 1'b1; TOF = 1'b1; EOCI = 1'b1; ETOI = 1'b1;
      tick();
      check("tmr_oc_IRQ2",  {7'd0, IRQ2}, 8'd1);
      check("tmr_oc_IRQ2V", {4'd0, IRQ2V}, 8'd4);
      check("tmr_oc_PEND",  PEND, 8'h0C);
      ICF = 1'b1; EICI = 1'b1;
      tick();
      check("tmr_ic_IRQ2V", {4'd0, IRQ2V}, 8'd6);
      check("tmr_ic_PEND",  PEND, 8'h1C);
      check("model_ic_IRQ2V", {4'd0, exp_irq2v}, 8'd6);
      EICI = 1'b0;
      tick();
      check("tmr_noic_IRQ2V", {4'd0, IRQ2V}, 8'd4);
      EOCI = 1'b0;
      tick();
      check("tmr_to_IRQ2V", {4'd0, IRQ2V}, 8'd2);
      ETOI = 1'b0;
      tick();
      check("tmr_off_IRQ2",  {7'd0, IRQ2}, 8'd0);
      check("tmr_off_IRQ2V", {4'd0, IRQ2V}, 8'd0);

      // SCI, then reset with a latched NMI
      SCIRQ = 1'b1;
      tick();
      check("sci_IRQ0", {7'd0, IRQ0}, 8'd1);
      check("sci_PEND", PEND, 8'h02);
      NMI_N = 1'b0;
      tick(); tick(); tick();
      check("pre_rst_NMI", {7'd0, NMI}, 8'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("mid_rst_NMI",  {7'd0, NMI},  8'd0);
      check("mid_rst_IRQ0", {7'd0, IRQ0}, 8'd0);
      check("mid_rst_PEND", PEND, 8'd0);
      check("model_mid_rst", exp_pend, 8'd0);
      NMI_N = 1'b1; SCIRQ = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
